// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, little-endian byte-addressed
// data memory, range check and write gating for the instruction in M.
module memory_stage #(
    parameter int DMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_ValE,
    input  logic [63:0] E_ValA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  E_dstM,
    input  logic        M_bubble,
    input  logic [3:0]  W_stat,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_ValE,
    output logic [63:0] M_ValA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_ValM,
    output logic [3:0]  m_stat,
    output logic        dmem_error
);
    localparam int AW = $clog2(DMEM_BYTES);

    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] S_ADR    = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t BUBBLE = '{stat: S_AOK, icode: 4'h1, cnd: 1'b0,
                                  val_e: 64'd0, val_a: 64'd0,
                                  dst_e: 4'hF, dst_m: 4'hF};

    m_reg_t      m_q;
    logic [7:0]  mem [DMEM_BYTES];
    logic [63:0] addr;
    logic [AW-1:0] addr_lo;
    logic        rd, wr, out_of_range, we;
    logic [63:0] rd_data;

    // M register: reset and bubble both load a nop bubble
    always_ff @(posedge clk) begin
        if (rst || M_bubble)
            m_q <= BUBBLE;
        else
            m_q <= '{stat: E_stat, icode: E_icode, cnd: e_Cnd, val_e: e_ValE,
                     val_a: E_ValA, dst_e: e_dstE, dst_m: E_dstM};
    end

    // Address source and access kind decoded from the icode in M
    always_comb begin
        rd   = 1'b0;
        wr   = 1'b0;
        addr = 64'd0;
        case (m_q.icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin addr = m_q.val_e; wr = 1'b1; end
            I_MRMOVQ:                  begin addr = m_q.val_e; rd = 1'b1; end
            I_POPQ, I_RET:             begin addr = m_q.val_a; rd = 1'b1; end
            default: ;
        endcase
    end

    // Unsigned compare also catches negative addresses (bit 63 set)
    assign out_of_range = addr > 64'(DMEM_BYTES - 8);
    assign dmem_error   = (rd || wr) && out_of_range;
    assign addr_lo      = addr[AW-1:0];

    // Byte b of the 8-byte word sits at addr+b (little-endian)
    for (genvar b = 0; b < 8; b++) begin : g_rd
        assign rd_data[8*b +: 8] = mem[addr_lo + AW'(b)];
    end

    assign m_ValM = (rd && !out_of_range) ? rd_data : 64'd0;
    assign m_stat = dmem_error ? S_ADR : m_q.stat;

    // Never commit a store behind an excepting instruction in write-back
    assign we = wr && !out_of_range && (m_q.stat == S_AOK) && (W_stat == S_AOK);

    // Store commits at the edge ending the M cycle; reads in that same cycle
    // see the old contents. Memory is not touched by rst (sim starts at zero).
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < 8; b++)
                mem[addr_lo + AW'(b)] <= m_q.val_a[8*b +: 8];
    end

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_Cnd   = m_q.cnd;
    assign M_ValE  = m_q.val_e;
    assign M_ValA  = m_q.val_a;
    assign M_dstE  = m_q.dst_e;
    assign M_dstM  = m_q.dst_m;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, round trips, faults, gating, bubbles.
module tb_memory_stage;
    localparam int DMEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, e_dstE, E_dstM, W_stat;
    logic        e_Cnd, M_bubble;
    logic [63:0] e_ValE, E_ValA;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM, m_stat;
    logic        M_Cnd, dmem_error;
    logic [63:0] M_ValE, M_ValA, m_ValM;
    int total = 0;
    int bad   = 0;

    memory_stage #(.DMEM_BYTES(DMEM_BYTES)) dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .e_Cnd(e_Cnd),
        .e_ValE(e_ValE), .E_ValA(E_ValA), .e_dstE(e_dstE), .E_dstM(E_dstM),
        .M_bubble(M_bubble), .W_stat(W_stat), .M_stat(M_stat), .M_icode(M_icode),
        .M_Cnd(M_Cnd), .M_ValE(M_ValE), .M_ValA(M_ValA), .M_dstE(M_dstE),
        .M_dstM(M_dstM), .m_ValM(m_ValM), .m_stat(m_stat), .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic [3:0] icode, input logic [63:0] ve, input logic [63:0] va);
        E_icode = icode;
        e_ValE  = ve;
        E_ValA  = va;
        e_Cnd   = 1'b0;
        e_dstE  = 4'hF;
        E_dstM  = 4'hF;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_e(4'h4, 64'h40, 64'hDEAD);
        E_stat = 4'h2; e_dstE = 4'h3; E_dstM = 4'h5; e_Cnd = 1'b1;
        step; step;
        total++; if (M_icode !== 4'h1) begin $display("FAIL reset_icode got=%h want=1", M_icode); bad++; end
        total++; if (M_stat !== 4'h1) begin $display("FAIL reset_stat got=%h want=1", M_stat); bad++; end
        total++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin $display("FAIL reset_dst got=%h/%h want=f/f", M_dstE, M_dstM); bad++; end
        total++; if (m_ValM !== 64'd0 || dmem_error !== 1'b0) begin $display("FAIL reset_mem got=%h/%b want=0/0", m_ValM, dmem_error); bad++; end
        rst = 1'b0; E_stat = 4'h1;
    endtask

    task automatic test_store_load;
        set_e(4'h4, 64'h10, 64'h0123456789ABCDEF);
        step;
        total++; if (M_icode !== 4'h4 || m_ValM !== 64'd0) begin $display("FAIL st_in_m got=%h/%h want=4/0", M_icode, m_ValM); bad++; end
        set_e(4'h5, 64'h10, 64'd0);
        step;
        total++; if (m_ValM !== 64'h0123456789ABCDEF) begin $display("FAIL load_rt got=%h want=0123456789abcdef", m_ValM); bad++; end
        total++; if (m_ValM[7:0] !== 8'hEF) begin $display("FAIL byte10 got=%h want=ef", m_ValM[7:0]); bad++; end
        set_e(4'h5, 64'h11, 64'd0);
        step;
        total++; if (m_ValM[55:0] !== 56'h0123456789ABCD) begin $display("FAIL load_off1 got=%h want=0123456789abcd", m_ValM[55:0]); bad++; end
    endtask

    task automatic test_stack;
        set_e(4'hA, 64'h1F8, 64'h55);
        step;
        set_e(4'hB, 64'h200, 64'h1F8);
        step;
        total++; if (m_ValM !== 64'h55) begin $display("FAIL pop_val got=%h want=55", m_ValM); bad++; end
        total++; if (M_ValE !== 64'h200 || m_stat !== 4'h1) begin $display("FAIL pop_vale got=%h/%h want=200/1", M_ValE, m_stat); bad++; end
    endtask

    task automatic test_addr_fault;
        set_e(4'h4, 64'(DMEM_BYTES - 8), 64'hA5A5_0000_1111_2222);
        step;
        total++; if (dmem_error !== 1'b0) begin $display("FAIL edge_inrange got=%b want=0", dmem_error); bad++; end
        set_e(4'h5, 64'(DMEM_BYTES - 7), 64'd0);
        step;
        total++; if (dmem_error !== 1'b1 || m_stat !== 4'h3 || m_ValM !== 64'd0) begin $display("FAIL past_end got=%b/%h/%h want=1/3/0", dmem_error, m_stat, m_ValM); bad++; end
        set_e(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF);
        step;
        total++; if (dmem_error !== 1'b1 || m_stat !== 4'h3) begin $display("FAIL neg_addr got=%b/%h want=1/3", dmem_error, m_stat); bad++; end
        set_e(4'h5, 64'(DMEM_BYTES - 8), 64'd0);
        step;
        total++; if (m_ValM !== 64'hA5A5_0000_1111_2222) begin $display("FAIL neg_nowrite got=%h want=a5a5000011112222", m_ValM); bad++; end
    endtask

    task automatic test_write_suppress;
        set_e(4'h4, 64'h30, 64'h1111_1111_1111_1111);
        step;
        set_e(4'h4, 64'h30, 64'h2222_2222_2222_2222);
        step;
        W_stat = 4'h2;
        #1;
        total++; if (m_stat !== 4'h1) begin $display("FAIL wstat_mstat got=%h want=1", m_stat); bad++; end
        E_stat = 4'h4;
        set_e(4'h4, 64'h30, 64'h3333_3333_3333_3333);
        step;
        W_stat = 4'h1;
        total++; if (m_stat !== 4'h4) begin $display("FAIL ins_mstat got=%h want=4", m_stat); bad++; end
        E_stat = 4'h1;
        set_e(4'h5, 64'h30, 64'd0);
        step;
        total++; if (m_ValM !== 64'h1111_1111_1111_1111) begin $display("FAIL suppress got=%h want=1111111111111111", m_ValM); bad++; end
    endtask

    task automatic test_bubble;
        set_e(4'h4, 64'h40, 64'h4444_0000_0000_4444);
        step;
        set_e(4'h4, 64'h40, 64'h5555_5555_5555_5555);
        M_bubble = 1'b1;
        step;
        total++; if (M_icode !== 4'h1 || M_ValA !== 64'd0 || M_dstE !== 4'hF) begin $display("FAIL bubble_reg got=%h/%h/%h want=1/0/f", M_icode, M_ValA, M_dstE); bad++; end
        M_bubble = 1'b0;
        set_e(4'h5, 64'h40, 64'd0);
        step;
        total++; if (M_icode !== 4'h5 || m_ValM !== 64'h4444_0000_0000_4444) begin $display("FAIL bubble_resume got=%h/%h want=5/4444000000004444", M_icode, m_ValM); bad++; end
    endtask

    task automatic test_reset_commit;
        set_e(4'h4, 64'h50, 64'h6666_6666_0000_0006);
        step;
        rst = 1'b1; M_bubble = 1'b1;
        set_e(4'h4, 64'h50, 64'h7777_7777_7777_7777);
        step;
        total++; if (M_icode !== 4'h1 || m_stat !== 4'h1 || dmem_error !== 1'b0 || M_dstM !== 4'hF) begin $display("FAIL rst_bub got=%h/%h/%b/%h want=1/1/0/f", M_icode, m_stat, dmem_error, M_dstM); bad++; end
        rst = 1'b0; M_bubble = 1'b0;
        set_e(4'h5, 64'h50, 64'd0);
        step;
        total++; if (m_ValM !== 64'h6666_6666_0000_0006) begin $display("FAIL rst_commit got=%h want=6666666600000006", m_ValM); bad++; end
    endtask

    initial begin
        rst = 1'b1; M_bubble = 1'b0; W_stat = 4'h1; E_stat = 4'h1;
        set_e(4'h1, 64'd0, 64'd0);
        test_reset;
        test_store_load;
        test_stack;
        test_addr_fault;
        test_write_suppress;
        test_bubble;
        test_reset_commit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
